bcd_display_driver: RTL and testbench

// - Sequential binary-to-decimal display stage between the CPU's 32-bit I/O output register and HEX7..HEX0.
// - Captures a value on a load strobe and converts it with iterative double-dabble (add-3 then shift, one bit per clock).
// - Commits all digits and active-low 7-seg patterns together, so the board shows only complete values and never flickers.

---
 rtl/display_pkg.sv | 22 ++
 rtl/bcd_display_driver_if.sv | 25 ++
 rtl/seg7_decode.sv | 18 +
 rtl/bcd_display_driver.sv | 163 ++++++++++++++++
 tb/tb_bcd_display_driver.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared types, constants and helpers for the BCD display driver.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } disp_state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_LUT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Decimal digits needed to hold any WIDTH-bit unsigned value (log10(2) ~ 0.301).
  function automatic int nbcd(input int width);
    return width * 301 / 1000 + 1;
  endfunction

endpackage

// File: rtl/bcd_display_driver_if.sv
// Load/value request and committed display outputs of the BCD display driver.
interface bcd_display_driver_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) ();

  logic                  load;
  logic [WIDTH-1:0]      value;
  logic                  busy;
  logic                  done;
  logic                  ovf;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [7*DIGITS-1:0]   hex_out;

  modport master (
    output load, value,
    input  busy, done, ovf, bcd_out, hex_out
  );

  modport slave (
    input  load, value,
    output busy, done, ovf, bcd_out, hex_out
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment pattern, with forced blank.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Decode one digit; non-decimal codes and blanked digits show nothing.
  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i && (bcd_i <= 4'd9)) begin
      seg_o = SEG_LUT[int'(bcd_i)];
    end
  end

endmodule

// File: rtl/bcd_display_driver.sv
// Sequential double-dabble converter feeding an 8-digit 7-segment display.
// A captured value is shifted in one bit per clock; all digits are committed
// together so the display never shows a partially converted number.
module bcd_display_driver
  import display_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int DIGITS        = 8,
  parameter int BLANK_LEADING = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_display_driver_if.slave bus
);

  localparam int NBCD  = nbcd(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  disp_state_t          state_q, state_d;
  logic [WIDTH-1:0]     shreg_q, shreg_d;
  logic [4*NBCD-1:0]    bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic [WIDTH-1:0]     pend_val_q, pend_val_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;
  logic [4*DIGITS-1:0]  bcd_out_q, bcd_out_d;
  logic [7*DIGITS-1:0]  hex_out_q, hex_out_d;
  logic [7*DIGITS-1:0]  hex_dec;
  logic [DIGITS-1:0]    blank;
  logic                 ovf_now;
  logic                 seen_nz;

  // Double-dabble correction: bump every nibble >= 5 by 3 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NBCD; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Overflow and leading-zero blanking, judged over every internal digit.
  always_comb begin
    ovf_now = 1'b0;
    blank   = '0;
    for (int i = DIGITS; i < NBCD; i++) begin
      ovf_now = ovf_now | (bcd_q[4*i +: 4] != 4'd0);
    end
    seen_nz = ovf_now;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen_nz  = seen_nz | (bcd_q[4*i +: 4] != 4'd0);
      blank[i] = (BLANK_LEADING != 0) && (i != 0) && !seen_nz;
    end
  end

  // One decoder per displayed digit.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    seg7_decode u_dec (
      .bcd_i   (bcd_q[4*g +: 4]),
      .blank_i (blank[g]),
      .seg_o   (hex_dec[7*g +: 7])
    );
  end

  // Next-state logic: FSM, shift datapath, pending slot and output commit.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    state_d    = state_q;
    shreg_d    = shreg_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    bcd_out_d  = bcd_out_q;
    hex_out_d  = hex_out_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          shreg_d = bus.value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, shreg_d} = {bcd_adj, shreg_q} << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = COMMIT;
        end
        if (bus.load) begin
          pend_d     = 1'b1;
          pend_val_d = bus.value;
        end
      end
      COMMIT: begin
        bcd_out_d = bcd_q[4*DIGITS-1:0];
        hex_out_d = hex_dec;
        ovf_d     = ovf_now;
        done_d    = 1'b1;
        // A strobe on this edge is the newest request, so it beats the queued one.
        if (bus.load || pend_q) begin
          shreg_d = bus.load ? bus.value : pend_val_q;
          bcd_d   = '0;
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Control and visible outputs: synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      bcd_out_q <= '0;
      hex_out_q <= {DIGITS{SEG_BLANK}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      bcd_out_q <= bcd_out_d;
      hex_out_q <= hex_out_d;
    end
  end

  // Datapath registers: always loaded before they are read.
  always_ff @(posedge clk) begin
    // NOTE: no reset here; control flags above decide when these contents matter.
    shreg_q    <= shreg_d;
    bcd_q      <= bcd_d;
    pend_val_q <= pend_val_d;
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.ovf     = ovf_q;
  assign bus.bcd_out = bcd_out_q;
  assign bus.hex_out = hex_out_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Randomized + directed bench for bcd_display_driver with a queue scoreboard.
module tb_bcd_display_driver;

  localparam int WIDTH  = 32;
  localparam int DIGITS = 8;

  logic clk;
  logic rst_n;
  int   cyc;

  bcd_display_driver_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus_if ();

  bcd_display_driver #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_LEADING(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    int          edge_n;
  } sb_t;

  typedef struct {
    logic [31:0] bcd;
    logic [55:0] hex;
    logic        ovf;
  } exp_t;

  sb_t  sb_q[$];
  int   checks;
  int   errors;
  int   done_count;
  logic busy_exp, busy_exp_next;
  logic prev_done;

  // Abstract model: a converter that is either free or busy for WIDTH+1 edges,
  // plus one latest-wins waiting slot.
  bit          m_active;
  int          m_rem;
  logic [31:0] m_val;
  bit          m_pend;
  logic [31:0] m_pend_val;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    busy_exp <= busy_exp_next;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Reference: plain decimal arithmetic on the value.
  function automatic exp_t ref_out(input logic [31:0] v);
    exp_t r;
    longint unsigned x = 64'(v);
    int d[10];
    int top = 0;
    for (int i = 0; i < 10; i++) begin
      d[i] = int'(x % 10);
      x    = x / 10;
      if (d[i] != 0) top = i;
    end
    r.ovf = (v >= 32'd100000000);
    r.bcd = '0;
    r.hex = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r.bcd[4*i +: 4] = 4'(d[i]);
      r.hex[7*i +: 7] = (i > top) ? 7'h7F : seg_of(d[i]);
    end
    return r;
  endfunction

  task automatic model_edge(input bit rn, input bit ld, input logic [31:0] v);
    int e = cyc + 1;
    if (!rn) begin
      m_active = 0;
      m_pend   = 0;
      sb_q.delete();
    end else if (!m_active) begin
      if (ld) begin
        m_active = 1;
        m_rem    = WIDTH + 1;
        m_val    = v;
      end
    end else begin
      if (ld) begin
        m_pend     = 1;
        m_pend_val = v;
      end
      m_rem--;
      if (m_rem == 0) begin
        sb_q.push_back('{v: m_val, edge_n: e});
        if (m_pend) begin
          m_val  = m_pend_val;
          m_pend = 0;
          m_rem  = WIDTH + 1;
        end else begin
          m_active = 0;
        end
      end
    end
    busy_exp_next = m_active;
  endtask

  // Drive one clock's worth of inputs (called just after a rising edge).
  task automatic cycle(input bit ld, input logic [31:0] v, input bit rn);
    bus_if.load  = ld;
    bus_if.value = v;
    rst_n        = rn;
    model_edge(rn, ld, v);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 1'b1);
  endtask

  // Monitor: sampled on the falling edge, independent of the stimulus.
  always @(negedge clk) begin
    check("busy", 64'(bus_if.busy), 64'(busy_exp));
    if (bus_if.done) begin
      done_count++;
      if (prev_done) begin
        errors++;
        checks++;
        $display("FAIL done_width: done high on consecutive cycles at cycle %0d", cyc);
      end
      if (sb_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL done_unexpected: got done, required no done at cycle %0d", cyc);
      end else begin
        sb_t  s;
        exp_t r;
        s = sb_q.pop_front();
        r = ref_out(s.v);
        check("commit_cycle", 64'(cyc), 64'(s.edge_n));
        check("bcd_out", 64'(bus_if.bcd_out), 64'(r.bcd));
        check("hex_out", 64'(bus_if.hex_out), 64'(r.hex));
        check("ovf", 64'(bus_if.ovf), 64'(r.ovf));
      end
    end
    prev_done = bus_if.done;
  end

  initial begin
    int dc;
    logic [31:0] rv;
    checks = 0; errors = 0; done_count = 0;
    busy_exp = 0; busy_exp_next = 0; prev_done = 0; cyc = 0;
    m_active = 0; m_pend = 0; m_rem = 0; m_val = '0; m_pend_val = '0;
    rst_n = 1'b0;
    bus_if.load = 1'b0;
    bus_if.value = '0;
    @(posedge clk);
    #1;

    // Reset held two cycles
    cycle(1'b0, 32'd0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0);
    check("rst_hex", 64'(bus_if.hex_out), 64'({8{7'h7F}}));
    check("rst_bcd", 64'(bus_if.bcd_out), 64'd0);
    check("rst_busy", 64'(bus_if.busy), 64'd0);
    check("rst_done", 64'(bus_if.done), 64'd0);
    check("rst_ovf", 64'(bus_if.ovf), 64'd0);

    // Zero shows a single '0'
    cycle(1'b1, 32'd0, 1'b1);
    idle(40);
    check("zero_hex", 64'(bus_if.hex_out), 64'({{7{7'h7F}}, 7'h40}));
    check("zero_bcd", 64'(bus_if.bcd_out), 64'd0);

    // 1234
    cycle(1'b1, 32'd1234, 1'b1);
    idle(40);
    check("d1234_hex", 64'(bus_if.hex_out),
          64'({{4{7'h7F}}, 7'h79, 7'h24, 7'h30, 7'h19}));
    check("d1234_bcd", 64'(bus_if.bcd_out), 64'h00001234);

    // All ones: overflow, no blanking
    cycle(1'b1, 32'hFFFFFFFF, 1'b1);
    idle(40);
    check("max_bcd", 64'(bus_if.bcd_out), 64'h94967295);
    check("max_ovf", 64'(bus_if.ovf), 64'd1);
    check("max_hex", 64'(bus_if.hex_out),
          64'({7'h10, 7'h19, 7'h10, 7'h02, 7'h78, 7'h24, 7'h10, 7'h12}));

    // Largest value that fits
    cycle(1'b1, 32'd99999999, 1'b1);
    idle(40);
    check("fit_bcd", 64'(bus_if.bcd_out), 64'h99999999);
    check("fit_ovf", 64'(bus_if.ovf), 64'd0);

    // Pending overwrite: 5, then 7 and 9 while busy; 7 is never shown
    dc = done_count;
    cycle(1'b1, 32'd5, 1'b1);
    idle(9);
    cycle(1'b1, 32'd7, 1'b1);
    idle(1);
    cycle(1'b1, 32'd9, 1'b1);
    idle(70);
    check("pend_dones", 64'(done_count - dc), 64'd2);
    check("pend_bcd", 64'(bus_if.bcd_out), 64'h00000009);

    // Reset mid-conversion aborts
    dc = done_count;
    cycle(1'b1, 32'd42, 1'b1);
    idle(14);
    cycle(1'b0, 32'd0, 1'b0);
    idle(40);
    check("abort_dones", 64'(done_count - dc), 64'd0);
    check("abort_hex", 64'(bus_if.hex_out), 64'({8{7'h7F}}));
    check("abort_bcd", 64'(bus_if.bcd_out), 64'd0);
    cycle(1'b1, 32'd42, 1'b1);
    idle(40);
    check("reload_bcd", 64'(bus_if.bcd_out), 64'h00000042);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: rv = $urandom;
        1: rv = $urandom_range(0, 999);
        2: rv = 32'd99999999 + $urandom_range(0, 2) - 1;
        default: rv = $urandom_range(0, 99999);
      endcase
      cycle(($urandom_range(0, 7) == 0), rv, 1'b1);
    end
    idle(80);
    check("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
